// File: rtl/dsp_control_if.sv
// Control bundle between the DSP sequencer (master) and the datapath/instruction memory (slave).
interface dsp_control_if #(
   parameter int PCW = 12,
   parameter int IW  = 16
);
   logic           run;
   logic [IW-1:0]  instr;
   logic           acc_zero;
   logic           pc_en;
   logic           pc_sel;
   logic [PCW-1:0] branch_target;
   logic           ir_en;
   logic           t_en;
   logic           p_en;
   logic           acc_en;
   logic           mem_we;
   logic           multInMux_ctrl;
   logic [3:0]     aluShifter_ctrl;
   logic [1:0]     aluInMux_ctrl;
   logic [2:0]     alu_ctrl;
   logic [2:0]     accumInMux_ctrl;
   logic [2:0]     accumShifter_ctrl;
   logic           busy;
   logic           illegal;

   modport master (
      input  run, instr, acc_zero,
      output pc_en, pc_sel, branch_target, ir_en, t_en, p_en, acc_en, mem_we,
             multInMux_ctrl, aluShifter_ctrl, aluInMux_ctrl, alu_ctrl,
             accumInMux_ctrl, accumShifter_ctrl, busy, illegal
   );

   modport slave (
      output run, instr, acc_zero,
      input  pc_en, pc_sel, branch_target, ir_en, t_en, p_en, acc_en, mem_we,
             multInMux_ctrl, aluShifter_ctrl, aluInMux_ctrl, alu_ctrl,
             accumInMux_ctrl, accumShifter_ctrl, busy, illegal
   );
endinterface

// File: rtl/dsp_control.sv
// Multi-cycle sequencer for the TMS32010-style datapath: fetch, decode, then one EXEC
// cycle (or BFETCH/BLOAD for two-word branches) driving every enable and mux select.
module dsp_control #(
   parameter int PCW = 12,
   parameter int IW  = 16
) (
   input  logic          clk,
   input  logic          reset,
   dsp_control_if.master bus
);
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_LAC  = 4'h2;
   localparam logic [3:0] OP_SACL = 4'h3;
   localparam logic [3:0] OP_LT   = 4'h4;
   localparam logic [3:0] OP_MPY  = 4'h5;
   localparam logic [3:0] OP_MPYK = 4'h6;
   localparam logic [3:0] OP_PAC  = 4'h7;
   localparam logic [3:0] OP_APAC = 4'h8;
   localparam logic [3:0] OP_LACK = 4'h9;
   localparam logic [3:0] OP_B    = 4'hA;
   localparam logic [3:0] OP_BZ   = 4'hB;
   localparam logic [3:0] OP_NOP  = 4'hC;

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, BFETCH, BLOAD} state_t;

   state_t         state, state_nxt;
   logic [3:0]     op_p1;
   logic [3:0]     shift_p1;
   logic [PCW-1:0] target_p1;
   logic [3:0]     op_live;

   assign op_live = bus.instr[IW-1 -: 4];

   function automatic logic is_branch(input logic [3:0] op);
      return (op == OP_B) || (op == OP_BZ);
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Decode stage: opcode and shift field held for the EXEC/BLOAD cycle
   always_ff @(posedge clk) begin
      if (state == DECODE) begin
         op_p1    <= op_live;
         shift_p1 <= bus.instr[IW-5 -: 4];
      end
   end

   // Branch-word stage: second word of B/BZ becomes the target
   always_ff @(posedge clk) begin
      if (!reset)               target_p1 <= '0;
      else if (state == BFETCH) target_p1 <= bus.instr[PCW-1:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:        if (bus.run) state_nxt = FETCH;
         FETCH:       state_nxt = DECODE;
         DECODE:      state_nxt = is_branch(op_live) ? BFETCH : EXEC;
         EXEC, BLOAD: state_nxt = bus.run ? FETCH : IDLE;
         BFETCH:      state_nxt = BLOAD;
         default:     state_nxt = IDLE;
      endcase
   end

   // Enables are gated by reset so a reset landing in BLOAD/EXEC never half-loads the PC.
   always_comb begin
      bus.pc_en             = 1'b0;
      bus.pc_sel            = 1'b0;
      bus.ir_en             = 1'b0;
      bus.t_en              = 1'b0;
      bus.p_en              = 1'b0;
      bus.acc_en            = 1'b0;
      bus.mem_we            = 1'b0;
      bus.multInMux_ctrl    = 1'b0;
      bus.aluShifter_ctrl   = 4'd0;
      bus.aluInMux_ctrl     = 2'd0;
      bus.alu_ctrl          = 3'd0;
      bus.accumInMux_ctrl   = 3'd0;
      bus.accumShifter_ctrl = 3'd0;
      bus.illegal           = 1'b0;
      if (reset) begin
         case (state)
            DECODE: begin
               bus.ir_en = 1'b1;
               bus.pc_en = is_branch(op_live);
            end
            EXEC: begin
               bus.pc_en = 1'b1;
               case (op_p1)
                  OP_ADD, OP_SUB: begin
                     bus.acc_en          = 1'b1;
                     bus.alu_ctrl        = (op_p1 == OP_SUB) ? 3'd1 : 3'd0;
                     bus.aluShifter_ctrl = shift_p1;
                  end
                  OP_LAC: begin
                     bus.acc_en          = 1'b1;
                     bus.accumInMux_ctrl = 3'd1;
                     bus.aluShifter_ctrl = shift_p1;
                  end
                  OP_SACL: begin
                     bus.mem_we            = 1'b1;
                     bus.accumShifter_ctrl = shift_p1[2:0];
                  end
                  OP_LT:   bus.t_en = 1'b1;
                  OP_MPY:  bus.p_en = 1'b1;
                  OP_MPYK: begin
                     bus.p_en           = 1'b1;
                     bus.multInMux_ctrl = 1'b1;
                  end
                  OP_PAC: begin
                     bus.acc_en          = 1'b1;
                     bus.accumInMux_ctrl = 3'd2;
                  end
                  OP_APAC: begin
                     bus.acc_en        = 1'b1;
                     bus.aluInMux_ctrl = 2'd1;
                  end
                  OP_LACK: begin
                     bus.acc_en          = 1'b1;
                     bus.accumInMux_ctrl = 3'd4;
                  end
                  OP_B, OP_BZ, OP_NOP: ;
                  default: bus.illegal = 1'b1;
               endcase
            end
            BLOAD: begin
               bus.pc_en  = 1'b1;
               bus.pc_sel = (op_p1 == OP_B) || ((op_p1 == OP_BZ) && bus.acc_zero);
            end
            default: ;
         endcase
      end
   end

   assign bus.busy          = (state != IDLE);
   assign bus.branch_target = target_p1;
endmodule

// File: tb/tb_dsp_control.sv
// Bench for dsp_control: instruction-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dsp_control;
   logic clk = 1'b0;
   logic reset;

   dsp_control_if #(.PCW(12), .IW(16)) bus ();
   dsp_control #(.PCW(12), .IW(16)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_en, pc_sel, ir_en, t_en, p_en, acc_en, mem_we, mult_in;
      logic [3:0] alu_sh;
      logic [1:0] alu_in;
      logic [2:0] alu;
      logic [2:0] acc_in;
      logic [2:0] acc_sh;
      logic       busy, illegal;
   } outs_t;

   int checks = 0, failures = 0, cyc_no = 0;
   int t_at = -1, p_at = -1, a_at = -1;
   outs_t got, exp_o;
   logic [11:0] got_tgt;

   // Model: whether an instruction is in flight, which cycle of it we are in,
   // and the instruction word latched when it was decoded.
   bit          m_active = 0;
   int          m_ph = 0;
   logic [3:0]  m_op = '0, m_s = '0;
   bit          m_br = 0;
   logic [11:0] m_tgt = '0;

   task automatic chk(input string name, input logic [63:0] g, input logic [63:0] e);
      checks++;
      if (g !== e) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, g, e, cyc_no);
      end
   endtask

   function automatic outs_t dut_outs();
      outs_t o;
      o.pc_en = bus.pc_en;   o.pc_sel = bus.pc_sel; o.ir_en = bus.ir_en;
      o.t_en = bus.t_en;     o.p_en = bus.p_en;     o.acc_en = bus.acc_en;
      o.mem_we = bus.mem_we; o.mult_in = bus.multInMux_ctrl;
      o.alu_sh = bus.aluShifter_ctrl; o.alu_in = bus.aluInMux_ctrl;
      o.alu = bus.alu_ctrl;  o.acc_in = bus.accumInMux_ctrl;
      o.acc_sh = bus.accumShifter_ctrl; o.busy = bus.busy; o.illegal = bus.illegal;
      return o;
   endfunction

   function automatic outs_t model_outs();
      outs_t o = '0;
      logic [3:0] live_op;
      live_op = bus.instr[15:12];
      o.busy = m_active;
      if (reset && m_active) begin
         if (m_ph == 1) begin
            o.ir_en = 1'b1;
            o.pc_en = (live_op == 4'hA) || (live_op == 4'hB);
         end else if (m_ph == 2 && !m_br) begin
            o.pc_en = 1'b1;
            case (m_op)
               4'h0: begin o.acc_en = 1; o.alu_sh = m_s; end
               4'h1: begin o.acc_en = 1; o.alu_sh = m_s; o.alu = 3'd1; end
               4'h2: begin o.acc_en = 1; o.alu_sh = m_s; o.acc_in = 3'd1; end
               4'h3: begin o.mem_we = 1; o.acc_sh = m_s[2:0]; end
               4'h4: o.t_en = 1;
               4'h5: o.p_en = 1;
               4'h6: begin o.p_en = 1; o.mult_in = 1; end
               4'h7: begin o.acc_en = 1; o.acc_in = 3'd2; end
               4'h8: begin o.acc_en = 1; o.alu_in = 2'd1; end
               4'h9: begin o.acc_en = 1; o.acc_in = 3'd4; end
               4'hD, 4'hE, 4'hF: o.illegal = 1;
               default: ;
            endcase
         end else if (m_ph == 3) begin
            o.pc_en  = 1'b1;
            o.pc_sel = (m_op == 4'hA) || bus.acc_zero;
         end
      end
      return o;
   endfunction

   task automatic model_step();
      if (!reset) begin
         m_active = 0;
         m_tgt = '0;
      end else if (!m_active) begin
         if (bus.run) begin m_active = 1; m_ph = 0; end
      end else if (m_ph == 0) begin
         m_ph = 1;
      end else if (m_ph == 1) begin
         m_op = bus.instr[15:12];
         m_s  = bus.instr[11:8];
         m_br = (m_op == 4'hA) || (m_op == 4'hB);
         m_ph = 2;
      end else if (m_ph == 2 && m_br) begin
         m_tgt = bus.instr[11:0];
         m_ph = 3;
      end else begin
         if (bus.run) m_ph = 0;
         else         m_active = 0;
      end
   endtask

   task automatic cyc(input logic rn, input logic r, input logic [15:0] w, input logic az);
      @(negedge clk);
      reset = rn; bus.run = r; bus.instr = w; bus.acc_zero = az;
      #1;
      got = dut_outs();
      got_tgt = bus.branch_target;
      exp_o = model_outs();
      chk("outputs", 64'(got), 64'(exp_o));
      chk("branch_target", 64'(got_tgt), 64'(m_tgt));
      if (got.t_en) t_at = cyc_no;
      if (got.p_en) p_at = cyc_no;
      if (got.acc_en) a_at = cyc_no;
      cyc_no++;
      @(posedge clk);
      model_step();
   endtask

   function automatic logic [15:0] rw();
      return 16'($urandom);
   endfunction

   initial begin
      reset = 1'b0; bus.run = 1'b1; bus.instr = '0; bus.acc_zero = 1'b0;
      @(posedge clk);
      model_step();

      // reset held with run=1
      cyc(0, 1, rw(), 1);
      cyc(0, 1, rw(), 1);
      chk("reset_all_zero", 64'(got), 64'd0);
      chk("reset_target", 64'(got_tgt), 64'd0);

      // release: IDLE, then FETCH/DECODE/EXEC of ADD S=3
      cyc(1, 1, rw(), 0);
      chk("idle_busy", 64'(got.busy), 64'd0);
      cyc(1, 1, rw(), 0);
      chk("fetch_busy", 64'(got.busy), 64'd1);
      chk("fetch_acc_en", 64'(got.acc_en), 64'd0);
      cyc(1, 1, 16'h0300, 0);
      chk("dec_ir_en", 64'(got.ir_en), 64'd1);
      chk("dec_quiet", 64'({got.acc_en, got.pc_en, got.alu_sh}), 64'd0);
      cyc(1, 1, rw(), 0);
      chk("add_shift", 64'(got.alu_sh), 64'd3);
      chk("add_en", 64'({got.acc_en, got.pc_en, got.pc_sel}), 64'b110);
      chk("add_sel", 64'({got.alu, got.alu_in, got.acc_in}), 64'd0);

      // LT, MPYK K=0xF6, PAC
      cyc(1, 1, rw(), 0); cyc(1, 1, 16'h4000, 0); cyc(1, 1, rw(), 0);
      chk("lt_t_en", 64'(got.t_en), 64'd1);
      cyc(1, 1, rw(), 0); cyc(1, 1, 16'h60F6, 0); cyc(1, 1, rw(), 0);
      chk("mpyk_p", 64'({got.p_en, got.mult_in}), 64'b11);
      cyc(1, 1, rw(), 0); cyc(1, 1, 16'h7000, 0); cyc(1, 1, rw(), 0);
      chk("pac_acc", 64'({got.acc_en, got.acc_in}), 64'b1010);
      chk("t_to_p_gap", 64'(p_at - t_at), 64'd3);
      chk("p_to_acc_gap", 64'(a_at - p_at), 64'd3);

      // BZ taken, then untaken
      cyc(1, 1, rw(), 1); cyc(1, 1, 16'hB000, 1); cyc(1, 1, 16'h0123, 1); cyc(1, 1, rw(), 1);
      chk("bz_taken_sel", 64'({got.pc_en, got.pc_sel}), 64'b11);
      chk("bz_target", 64'(got_tgt), 64'h123);
      cyc(1, 1, rw(), 0); cyc(1, 1, 16'hB000, 0); cyc(1, 1, 16'h0123, 0); cyc(1, 1, rw(), 0);
      chk("bz_untaken_sel", 64'({got.pc_en, got.pc_sel}), 64'b10);

      // illegal opcode
      cyc(1, 1, rw(), 0); cyc(1, 1, 16'hE000, 0); cyc(1, 1, rw(), 0);
      chk("illegal_pulse", 64'(got.illegal), 64'd1);
      chk("illegal_quiet", 64'({got.acc_en, got.t_en, got.p_en, got.mem_we}), 64'd0);
      cyc(1, 1, rw(), 0);
      chk("illegal_gone", 64'(got.illegal), 64'd0);

      // run dropped while a branch is in DECODE
      cyc(1, 0, 16'hA000, 0); cyc(1, 0, 16'h0456, 0); cyc(1, 0, rw(), 0);
      chk("b_load_sel", 64'({got.pc_en, got.pc_sel}), 64'b11);
      cyc(1, 1, rw(), 0);
      chk("parked_idle", 64'(got.busy), 64'd0);

      // reset during BFETCH
      cyc(1, 1, rw(), 0); cyc(1, 1, 16'hA000, 0); cyc(0, 1, 16'h0789, 0);
      chk("rst_bfetch_pc_en", 64'(got.pc_en), 64'd0);
      cyc(1, 0, rw(), 0);
      chk("rst_to_idle", 64'({got.busy, got.pc_en}), 64'd0);
      chk("rst_target_clear", 64'(got_tgt), 64'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++)
         cyc(logic'($urandom_range(0, 49) != 0), logic'($urandom_range(0, 7) != 0),
             rw(), logic'($urandom_range(0, 1)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
